sonar_scan_controller: RTL and testbench

- Drives up to NUM_CH ultrasonic ranging sensors (trigger/echo pairs) from one clock domain.
- Fires one channel at a time, in single-shot or continuous round-robin mode.
- Measures each echo pulse width, converts it to millimetres with saturation, and emits one result per measurement.
- Flags timeouts per result.
- Sits between the sensor pins and the detection/display logic; replaces the single-channel ranging controller.

---
 rtl/sonar_pkg.sv | 49 ++++
 rtl/sonar_echo_sync.sv | 26 ++
 rtl/sonar_scan_controller.sv | 183 ++++++++++++++++++
 tb/tb_sonar_scan_controller.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sonar_pkg.sv
// Shared types and helpers for the multi-channel sonar ranging controller.
package sonar_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIGGER,
        WAIT_ECHO,
        MEASURE,
        REPORT,
        HOLDOFF
    } sonar_state_e;

    localparam int MAX_CH = 8;

    // Round-robin pick: first enabled channel strictly after cur, wrapping; cur if none.
    function automatic logic [2:0] next_ch(input logic [MAX_CH-1:0] mask,
                                           input logic [2:0]        cur,
                                           input int                numCh);
        logic [2:0] pick;
        int         idx;
        pick = cur;
        for (int i = MAX_CH; i >= 1; i--) begin
            if (i <= numCh) begin
                idx = (int'(cur) + i) % numCh;
                if (mask[3'(idx)]) begin
                    pick = 3'(idx);
                end
            end
        end
        return pick;
    endfunction

    // Full-width multiply, shift, then clamp to distW bits (or force all-ones on timeout).
    function automatic logic [31:0] cyc_to_mm(input logic [31:0] cyc,
                                              input int          mul,
                                              input int          shift,
                                              input int          distW,
                                              input logic        timeout);
        logic [63:0] prod;
        logic [63:0] maxVal;
        maxVal = (64'd1 << distW) - 64'd1;
        prod   = (64'(cyc) * 64'(mul)) >> shift;
        if (timeout || (prod > maxVal)) begin
            prod = maxVal;
        end
        return prod[31:0];
    endfunction

endpackage

// File: rtl/sonar_echo_sync.sv
// Two-flop synchronizer bank bringing the asynchronous echo pins into the clk domain.
module sonar_echo_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] echo_i,
    output logic [WIDTH-1:0] echo_o
);

    logic [WIDTH-1:0] stage1_q;
    logic [WIDTH-1:0] stage2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage1_q <= '0;
            stage2_q <= '0;
        end else begin
            stage1_q <= echo_i;
            stage2_q <= stage1_q;
        end
    end

    assign echo_o = stage2_q;

endmodule

// File: rtl/sonar_scan_controller.sv
// Multi-channel ultrasonic ranging controller: triggers one sensor at a time,
// times its echo and reports the distance in millimetres.
module sonar_scan_controller
    import sonar_pkg::*;
#(
    parameter int NUM_CH           = 4,
    parameter int TRIG_CYC         = 1000,
    parameter int ECHO_TIMEOUT_CYC = 3000000,
    parameter int ECHO_MAX_CYC     = 3000000,
    parameter int HOLDOFF_CYC      = 6000000,
    parameter int DIST_W           = 16,
    parameter int MM_MUL           = 225,
    parameter int MM_SHIFT         = 17,
    localparam int CH_W            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              continuous,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic [NUM_CH-1:0] trig_out,
    input  logic [NUM_CH-1:0] echo_in,
    output logic              busy,
    output logic              dist_valid,
    output logic [CH_W-1:0]   dist_ch,
    output logic [DIST_W-1:0] dist_mm,
    output logic              dist_timeout
);

    localparam int MAX_AB  = (TRIG_CYC > ECHO_TIMEOUT_CYC) ? TRIG_CYC : ECHO_TIMEOUT_CYC;
    localparam int MAX_CD  = (ECHO_MAX_CYC > HOLDOFF_CYC) ? ECHO_MAX_CYC : HOLDOFF_CYC;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ECHO_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] ECHO_LIMIT   = CNT_W'(ECHO_MAX_CYC);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLDOFF_CYC - 1);
    localparam logic [CH_W-1:0]  CH_RESET     = CH_W'(NUM_CH - 1);

    sonar_state_e      state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CH_W-1:0]   chSel_q;
    logic              echoSel_q;
    logic [NUM_CH-1:0] trig_q;
    logic              busy_q;
    logic              distValid_q;
    logic [CH_W-1:0]   distCh_q;
    logic [DIST_W-1:0] distMm_q;
    logic              distTimeout_q;

    logic [NUM_CH-1:0] echoSync;
    logic [MAX_CH-1:0] maskPad;
    logic [2:0]        curPad;
    logic [CH_W-1:0]   nextCh_d;
    logic [NUM_CH-1:0] nextOneHot_d;
    logic [DIST_W-1:0] mm_d;

    sonar_echo_sync #(
        .WIDTH (NUM_CH)
    ) u_echo_sync (
        .clk    (clk),
        .rst    (rst),
        .echo_i (echo_in),
        .echo_o (echoSync)
    );

    always_comb begin
        maskPad      = MAX_CH'(ch_mask);
        curPad       = 3'(chSel_q);
        nextCh_d     = CH_W'(next_ch(maskPad, curPad, NUM_CH));
        nextOneHot_d = '0;
        nextOneHot_d[nextCh_d] = 1'b1;
        mm_d         = DIST_W'(cyc_to_mm(32'(cnt_q), MM_MUL, MM_SHIFT, DIST_W, 1'b0));
    end

    // The selected echo is registered once more so every state sees a stable,
    // channel-qualified level; this extra stage is part of the fall-to-strobe latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            chSel_q       <= CH_RESET;
            echoSel_q     <= 1'b0;
            trig_q        <= '0;
            busy_q        <= 1'b0;
            distValid_q   <= 1'b0;
            distCh_q      <= '0;
            distMm_q      <= '0;
            distTimeout_q <= 1'b0;
        end else begin
            echoSel_q   <= echoSync[chSel_q];
            distValid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if ((start || continuous) && (ch_mask != '0)) begin
                        chSel_q <= nextCh_d;
                        trig_q  <= nextOneHot_d;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= TRIGGER;
                    end
                end
                TRIGGER: begin
                    if (cnt_q == TRIG_LAST) begin
                        trig_q  <= '0;
                        cnt_q   <= '0;
                        state_q <= WAIT_ECHO;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WAIT_ECHO: begin
                    if (echoSel_q) begin
                        cnt_q   <= CNT_W'(1);
                        state_q <= MEASURE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        distValid_q   <= 1'b1;
                        distCh_q      <= chSel_q;
                        distMm_q      <= '1;
                        distTimeout_q <= 1'b1;
                        cnt_q         <= '0;
                        state_q       <= REPORT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                MEASURE: begin
                    if (!echoSel_q) begin
                        distValid_q   <= 1'b1;
                        distCh_q      <= chSel_q;
                        distMm_q      <= mm_d;
                        distTimeout_q <= 1'b0;
                        cnt_q         <= '0;
                        state_q       <= REPORT;
                    end else if (cnt_q == ECHO_LIMIT) begin
                        distValid_q   <= 1'b1;
                        distCh_q      <= chSel_q;
                        distMm_q      <= '1;
                        distTimeout_q <= 1'b1;
                        cnt_q         <= '0;
                        state_q       <= REPORT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                REPORT: begin
                    cnt_q   <= '0;
                    state_q <= HOLDOFF;
                end
                HOLDOFF: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_q <= '0;
                        if (continuous && (ch_mask != '0)) begin
                            chSel_q <= nextCh_d;
                            trig_q  <= nextOneHot_d;
                            state_q <= TRIGGER;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    trig_q  <= '0;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign trig_out     = trig_q;
    assign busy         = busy_q;
    assign dist_valid   = distValid_q;
    assign dist_ch      = distCh_q;
    assign dist_mm      = distMm_q;
    assign dist_timeout = distTimeout_q;

endmodule

// File: tb/tb_sonar_scan_controller.sv
// Directed self-checking bench for sonar_scan_controller using short simulation timings.
module tb_sonar_scan_controller;

    logic       clk;
    logic       rst;
    logic       start;
    logic       continuous;
    logic [3:0] ch_mask;
    logic [3:0] trig_out;
    logic [3:0] echo_in;
    logic       busy;
    logic       dist_valid;
    logic [1:0] dist_ch;
    logic [15:0] dist_mm;
    logic       dist_timeout;

    int total = 0;
    int bad   = 0;

    sonar_scan_controller #(
        .NUM_CH           (4),
        .TRIG_CYC         (10),
        .ECHO_TIMEOUT_CYC (100),
        .ECHO_MAX_CYC     (5000),
        .HOLDOFF_CYC      (20),
        .DIST_W           (16),
        .MM_MUL           (225),
        .MM_SHIFT         (17)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .continuous   (continuous),
        .ch_mask      (ch_mask),
        .trig_out     (trig_out),
        .echo_in      (echo_in),
        .busy         (busy),
        .dist_valid   (dist_valid),
        .dist_ch      (dist_ch),
        .dist_mm      (dist_mm),
        .dist_timeout (dist_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tickN(input int n);
        repeat (n) tick();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic c, input logic [3:0] m);
        start      = s;
        continuous = c;
        ch_mask    = m;
    endtask

    task automatic waitTrigOn(input string tag);
        int n = 0;
        while (trig_out == 4'b0000 && n < 300) begin
            tick();
            n++;
        end
        checkOutput({tag, "_trigSeen"}, 32'(trig_out != 4'b0000), 32'd1);
    endtask

    task automatic waitTrigOff(output int width);
        width = 0;
        while (trig_out != 4'b0000 && width < 50) begin
            width++;
            tick();
        end
    endtask

    task automatic waitValid(input string tag);
        int n = 0;
        while (!dist_valid && n < 6000) begin
            tick();
            n++;
        end
        checkOutput({tag, "_validSeen"}, 32'(dist_valid), 32'd1);
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    // Linear directed sequence; all sampling and driving happens 1 time unit after a rising edge.
    initial begin
        int         width;
        int         trigCount;
        int         order [6];
        logic [3:0] expOneHot;

        order   = '{0, 1, 3, 0, 1, 3};
        rst     = 1'b1;
        echo_in = 4'b0000;
        applyStimulus(1'b0, 1'b0, 4'b0000);
        tickN(2);
        checkOutput("rst_trig", 32'(trig_out), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_valid", 32'(dist_valid), 32'h0);
        checkOutput("rst_ch", 32'(dist_ch), 32'h0);
        checkOutput("rst_mm", 32'(dist_mm), 32'h0);
        checkOutput("rst_tmo", 32'(dist_timeout), 32'h0);
        rst = 1'b0;
        tick();

        // Single shot on channel 2, echo high for 1166 cycles -> 2 mm.
        applyStimulus(1'b1, 1'b0, 4'b0100);
        tick();
        start = 1'b0;
        checkOutput("s1_trig", 32'(trig_out), 32'h4);
        checkOutput("s1_busy", 32'(busy), 32'h1);
        waitTrigOff(width);
        checkOutput("s1_trigWidth", 32'(width), 32'd10);
        echo_in[2] = 1'b1;
        tickN(1166);
        echo_in[2] = 1'b0;
        tickN(3);
        checkOutput("s1_validEarly", 32'(dist_valid), 32'h0);
        tick();
        checkOutput("s1_valid", 32'(dist_valid), 32'h1);
        checkOutput("s1_ch", 32'(dist_ch), 32'd2);
        checkOutput("s1_mm", 32'(dist_mm), 32'd2);
        checkOutput("s1_tmo", 32'(dist_timeout), 32'd0);
        tick();
        checkOutput("s1_validPulse", 32'(dist_valid), 32'h0);
        checkOutput("s1_mmHold", 32'(dist_mm), 32'd2);
        tickN(19);
        checkOutput("s1_busyHold", 32'(busy), 32'h1);
        tick();
        checkOutput("s1_busyDone", 32'(busy), 32'h0);

        // Timeout on channel 0 with no echo.
        applyStimulus(1'b1, 1'b0, 4'b0001);
        tick();
        start = 1'b0;
        checkOutput("s2_trig", 32'(trig_out), 32'h1);
        waitTrigOff(width);
        checkOutput("s2_trigWidth", 32'(width), 32'd10);
        tickN(99);
        checkOutput("s2_validEarly", 32'(dist_valid), 32'h0);
        tick();
        checkOutput("s2_valid", 32'(dist_valid), 32'h1);
        checkOutput("s2_ch", 32'(dist_ch), 32'd0);
        checkOutput("s2_mm", 32'(dist_mm), 32'hFFFF);
        checkOutput("s2_tmo", 32'(dist_timeout), 32'd1);
        waitIdle("s2");

        // Echo stuck high: forced abort when the count reaches 5000.
        applyStimulus(1'b1, 1'b0, 4'b0001);
        tick();
        start = 1'b0;
        waitTrigOff(width);
        echo_in[0] = 1'b1;
        tickN(5003);
        checkOutput("s3_validEarly", 32'(dist_valid), 32'h0);
        tick();
        checkOutput("s3_valid", 32'(dist_valid), 32'h1);
        checkOutput("s3_mm", 32'(dist_mm), 32'hFFFF);
        checkOutput("s3_tmo", 32'(dist_timeout), 32'd1);
        checkOutput("s3_echoStillHigh", 32'(echo_in[0]), 32'd1);
        tickN(996);
        echo_in[0] = 1'b0;
        waitIdle("s3");
        tickN(5);

        // Continuous round-robin over mask 1011, starting from a fresh reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1, 4'b1011);
        for (int k = 0; k < 6; k++) begin
            waitTrigOn("s4");
            expOneHot = 4'b0001 << order[k];
            checkOutput("s4_trigOrder", 32'(trig_out), 32'(expOneHot));
            waitTrigOff(width);
            echo_in[order[k]] = 1'b1;
            tickN(600 * (k + 1));
            echo_in = 4'b0000;
            waitValid("s4");
            checkOutput("s4_ch", 32'(dist_ch), 32'(order[k]));
            checkOutput("s4_mm", 32'(dist_mm), 32'(k + 1));
        end

        // Continuous dropped mid-measurement of channel 1.
        waitTrigOn("s5");
        checkOutput("s5_trig0", 32'(trig_out), 32'h1);
        waitTrigOff(width);
        echo_in[0] = 1'b1;
        tickN(600);
        echo_in[0] = 1'b0;
        waitValid("s5a");
        checkOutput("s5_ch0", 32'(dist_ch), 32'd0);
        waitTrigOn("s5b");
        checkOutput("s5_trig1", 32'(trig_out), 32'h2);
        waitTrigOff(width);
        echo_in[1] = 1'b1;
        tickN(300);
        continuous = 1'b0;
        tickN(300);
        echo_in[1] = 1'b0;
        waitValid("s5c");
        checkOutput("s5_ch1", 32'(dist_ch), 32'd1);
        checkOutput("s5_mm1", 32'(dist_mm), 32'd1);
        checkOutput("s5_tmo", 32'(dist_timeout), 32'd0);
        waitIdle("s5");
        trigCount = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (trig_out != 4'b0000) trigCount++;
        end
        checkOutput("s5_noTrig", 32'(trigCount), 32'd0);

        // Reset asserted during TRIGGER, then start ignored with an empty mask.
        applyStimulus(1'b1, 1'b0, 4'b0100);
        tick();
        start = 1'b0;
        checkOutput("s6_trig", 32'(trig_out), 32'h4);
        tickN(3);
        rst = 1'b1;
        tick();
        checkOutput("s6_rstTrig", 32'(trig_out), 32'h0);
        checkOutput("s6_rstBusy", 32'(busy), 32'h0);
        checkOutput("s6_rstValid", 32'(dist_valid), 32'h0);
        checkOutput("s6_rstMm", 32'(dist_mm), 32'h0);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 4'b0000);
        tick();
        start = 1'b0;
        checkOutput("s6_emptyBusy", 32'(busy), 32'h0);
        tickN(5);
        checkOutput("s6_emptyTrig", 32'(trig_out), 32'h0);
        checkOutput("s6_emptyBusy2", 32'(busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
